// File: rtl/brq_pkg.sv
// Shared types and widths for the branch resolve queue and its neighbours.
package brq_pkg;

  // Default widths, shared with the predictor table and the fetch stage.
  localparam int unsigned BRQ_IDX_W = 8;
  localparam int unsigned BRQ_PC_W  = 32;

  // One in-flight predicted branch, at the default widths.
  typedef struct packed {
    logic [BRQ_IDX_W-1:0] index;
    logic                 pred;
    logic [BRQ_PC_W-1:0]  alt_pc;
  } brq_entry_t;

  localparam int unsigned BRQ_ENTRY_W = $bits(brq_entry_t);

  // Packed entry width for non-default index/PC widths.
  function automatic int unsigned brq_entry_w(input int unsigned idx_w,
                                              input int unsigned pc_w);
    return idx_w + 1 + pc_w;
  endfunction

endpackage

// File: rtl/brq_storage.sv
// Register file holding in-flight entries: one write port (tail), one read port (head).
module brq_storage #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 41
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_ptr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the entry presented at the tail slot.
  // NOTE: the array has no reset; a slot is only ever read after it was written, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; drives predictor updates and mispredict redirects.
module branch_resolve_queue
  import brq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = BRQ_IDX_W,
  parameter int unsigned PC_W  = BRQ_PC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [IDX_W-1:0]         push_index,
  input  logic                     push_pred,
  input  logic [PC_W-1:0]          push_alt_pc,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     upd_valid,
  output logic [IDX_W-1:0]         upd_index,
  output logic                     upd_taken,
  output logic                     flush,
  output logic [PC_W-1:0]          redirect_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_underflow
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = brq_entry_w(IDX_W, PC_W);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [ENTRY_W-1:0] head_entry;
  logic [IDX_W-1:0]   head_index;
  logic               head_pred;
  logic [PC_W-1:0]    head_alt_pc;

  logic push_fire;
  logic resolve_live;
  logic pop_fire;
  logic mispredict;
  logic underflow;

  brq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_storage (
    .clk     (clk),
    .wr_en   (push_fire),
    .wr_ptr  (tail),
    .wr_data ({push_index, push_pred, push_alt_pc}),
    .rd_ptr  (head),
    .rd_data (head_entry)
  );

  assign {head_index, head_pred, head_alt_pc} = head_entry;

  // Ready depends only on registered state, so a same-cycle resolve never frees a slot.
  assign push_ready   = (count < FULL_COUNT) && !flush;
  assign push_fire    = push_valid && push_ready;
  // Resolves arriving in the flush cycle belong to the wrong path and are dropped.
  assign resolve_live = resolve_valid && !flush;
  assign pop_fire     = resolve_live && (count != '0);
  assign underflow    = resolve_live && (count == '0);
  assign mispredict   = pop_fire && (resolve_taken != head_pred);

  // Pointers and occupancy; a mispredict empties the queue, including any same-cycle push.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (mispredict) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (push_fire) tail <= tail + 1'b1;
      if (pop_fire)  head <= head + 1'b1;
      unique case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Registered predictor update, flush pulse, redirect target and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_valid     <= 1'b0;
      upd_index     <= '0;
      upd_taken     <= 1'b0;
      flush         <= 1'b0;
      redirect_pc   <= '0;
      err_underflow <= 1'b0;
    end else begin
      upd_valid <= pop_fire;
      flush     <= mispredict;
      if (pop_fire) begin
        upd_index <= head_index;
        upd_taken <= resolve_taken;
      end
      if (mispredict) redirect_pc   <= head_alt_pc;
      if (underflow)  err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench: directed scenarios then random traffic against a queue-based model.
module tb_branch_resolve_queue;
  import brq_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 push_valid;
  logic                 push_ready;
  logic [BRQ_IDX_W-1:0] push_index;
  logic                 push_pred;
  logic [BRQ_PC_W-1:0]  push_alt_pc;
  logic                 resolve_valid;
  logic                 resolve_taken;
  logic                 upd_valid;
  logic [BRQ_IDX_W-1:0] upd_index;
  logic                 upd_taken;
  logic                 flush;
  logic [BRQ_PC_W-1:0]  redirect_pc;
  logic [2:0]           count;
  logic                 err_underflow;

  branch_resolve_queue #(
    .DEPTH (DEPTH),
    .IDX_W (BRQ_IDX_W),
    .PC_W  (BRQ_PC_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .push_valid    (push_valid),
    .push_ready    (push_ready),
    .push_index    (push_index),
    .push_pred     (push_pred),
    .push_alt_pc   (push_alt_pc),
    .resolve_valid (resolve_valid),
    .resolve_taken (resolve_taken),
    .upd_valid     (upd_valid),
    .upd_index     (upd_index),
    .upd_taken     (upd_taken),
    .flush         (flush),
    .redirect_pc   (redirect_pc),
    .count         (count),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the queue contents plus the observable output registers.
  brq_entry_t           q[$];
  logic                 m_upd_valid;
  logic [BRQ_IDX_W-1:0] m_upd_index;
  logic                 m_upd_taken;
  logic                 m_flush;
  logic [BRQ_PC_W-1:0]  m_redirect;
  logic                 m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic accept;
    brq_entry_t e;
    accept = push_valid && (q.size() < DEPTH) && !m_flush;
    if (rst) begin
      q.delete();
      m_upd_valid = 1'b0;
      m_upd_index = '0;
      m_upd_taken = 1'b0;
      m_flush     = 1'b0;
      m_redirect  = '0;
      m_err       = 1'b0;
    end else begin
      logic was_flush;
      was_flush   = m_flush;
      m_upd_valid = 1'b0;
      m_flush     = 1'b0;
      if (resolve_valid && !was_flush) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          m_upd_valid = 1'b1;
          m_upd_index = e.index;
          m_upd_taken = resolve_taken;
          if (resolve_taken != e.pred) begin
            m_flush    = 1'b1;
            m_redirect = e.alt_pc;
            q.delete();
            accept = 1'b0;
          end
        end else begin
          m_err = 1'b1;
        end
      end
      if (accept) q.push_back('{index: push_index, pred: push_pred, alt_pc: push_alt_pc});
    end
  endtask

  task automatic check_outputs();
    check("count",         64'(count),         64'(q.size()));
    check("push_ready",    64'(push_ready),    64'((q.size() < DEPTH) && !m_flush));
    check("upd_valid",     64'(upd_valid),     64'(m_upd_valid));
    check("upd_index",     64'(upd_index),     64'(m_upd_index));
    check("upd_taken",     64'(upd_taken),     64'(m_upd_taken));
    check("flush",         64'(flush),         64'(m_flush));
    check("redirect_pc",   64'(redirect_pc),   64'(m_redirect));
    check("err_underflow", 64'(err_underflow), 64'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic pv, input logic [7:0] idx, input logic pred,
                       input logic [31:0] alt, input logic rv, input logic rt);
    push_valid    = pv;
    push_index    = idx;
    push_pred     = pred;
    push_alt_pc   = alt;
    resolve_valid = rv;
    resolve_taken = rt;
    step();
  endtask

  initial begin
    logic rt;
    rst = 1'b1;
    push_valid = 1'b0; push_index = '0; push_pred = 1'b0; push_alt_pc = '0;
    resolve_valid = 1'b0; resolve_taken = 1'b0;
    m_upd_valid = 1'b0; m_upd_index = '0; m_upd_taken = 1'b0;
    m_flush = 1'b0; m_redirect = '0; m_err = 1'b0;
    #1;
    step();
    step();
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) drive(1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0);
    check("idle_ready", 64'(push_ready), 64'd1);

    // Single correct prediction.
    drive(1'b1, 8'h12, 1'b1, 32'h100, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 32'h0,   1'b1, 1'b1);
    check("single_upd_index", 64'(upd_index), 64'h12);
    check("single_flush",     64'(flush),     64'd0);

    // Mispredict on the oldest of three.
    drive(1'b1, 8'h21, 1'b0, 32'h200, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 32'h204, 1'b0, 1'b0);
    drive(1'b1, 8'h23, 1'b0, 32'h208, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 32'h0,   1'b1, 1'b1);
    check("mp_redirect", 64'(redirect_pc), 64'h200);
    check("mp_ready",    64'(push_ready),  64'd0);
    drive(1'b0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b1);
    check("mp_after_ready", 64'(push_ready), 64'd1);

    // Fill, blocked push with same-cycle resolve, then wrap with paired traffic.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h40 + i), 1'b1, 32'(32'h400 + 4 * i), 1'b0, 1'b0);
    check("full_ready", 64'(push_ready), 64'd0);
    drive(1'b1, 8'h44, 1'b1, 32'h410, 1'b1, 1'b1);
    check("full_count", 64'(count), 64'd3);
    for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h50 + i), 1'b1, 32'(32'h500 + 4 * i), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b1);
    check("wrap_last_index", 64'(upd_index), 64'h57);

    // Underflow is sticky through later traffic.
    drive(1'b0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b0);
    check("uf_flag", 64'(err_underflow), 64'd1);
    drive(1'b1, 8'h60, 1'b0, 32'h600, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 32'h0,   1'b1, 1'b0);

    // Reset with entries queued and a resolve pending.
    drive(1'b1, 8'h70, 1'b1, 32'h700, 1'b0, 1'b0);
    drive(1'b1, 8'h71, 1'b0, 32'h704, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b0);
    rst = 1'b0;
    check("rst_count", 64'(count), 64'd0);
    drive(1'b0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b0);
    check("rst_then_uf", 64'(err_underflow), 64'd1);

    // Random traffic; resolutions mostly agree with the head prediction.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (q.size() > 0) rt = ($urandom_range(0, 4) == 0) ? !q[0].pred : q[0].pred;
      else              rt = 1'($urandom_range(0, 1));
      drive(($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom_range(0, 1)),
            $urandom, ($urandom_range(0, 9) < 5), rt);
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Sits between fetch/execute and the 2-bit branch predictor table.
- Records every predicted branch at fetch: table index, predicted direction and alternate-path PC. Entries are held in program order.
- When execute resolves the oldest branch, drives the predictor's update interface (update/index/actual_taken) one cycle later.
- On a misprediction, flushes all younger in-flight entries and issues a pipeline redirect to the alternate PC.

Parameters:
- DEPTH, 4, number of in-flight branch entries; must be a power of two, >= 2.
- IDX_W, 8, predictor table index width.
- PC_W, 32, program counter width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- push_valid  in  1  fetch presents a predicted branch
- push_ready  out  1  queue can accept push this cycle
- push_index  in  IDX_W  predictor index used at fetch
- push_pred  in  1  predicted direction (1 = taken)
- push_alt_pc  in  PC_W  PC of the non-predicted path
- resolve_valid  in  1  execute resolves the oldest branch
- resolve_taken  in  1  actual branch outcome
- upd_valid  out  1  to predictor update
- upd_index  out  IDX_W  to predictor index
- upd_taken  out  1  to predictor actual_taken
- flush  out  1  one-cycle pipeline flush pulse
- redirect_pc  out  PC_W  fetch target, valid while flush = 1
- count  out  $clog2(DEPTH)+1  entries currently held
- err_underflow  out  1  sticky: resolve arrived with queue empty

Behaviour:
- Reset (rst = 1 at a clk edge):
  - head/tail pointers = 0, count = 0.
  - upd_valid = 0, upd_index = 0, upd_taken = 0.
  - flush = 0, redirect_pc = 0, err_underflow = 0.
  - Reset asserted mid-operation discards all entries; no update or flush is emitted for them.
- push_ready = (count < DEPTH) && !flush. It is combinational from registered state only; it does not depend on resolve_valid.
  - Full queue + same-cycle resolve: push_ready still 0 (no bypass).
- Push accepted when push_valid && push_ready.
  - Entry {push_index, push_pred, push_alt_pc} is written at the tail.
  - Tail increments modulo DEPTH (natural wrap).
- Resolve with count > 0:
  - Head entry is popped in the same edge; head increments modulo DEPTH.
  - Next cycle: upd_valid = 1, upd_index = head.index, upd_taken = resolve_taken.
  - Latency from resolve to update is exactly 1 cycle. upd_valid is a single-cycle pulse per resolve.
- Mispredict (resolve_taken != head.pred):
  - Next cycle: flush = 1 and redirect_pc = head.alt_pc.
  - On the same edge, all remaining entries are discarded: count = 0, head = tail.
  - A push accepted in the same cycle as a mispredicting resolve is also discarded (it is wrong-path).
  - During the flush cycle push_ready = 0; resolve_valid is ignored.
  - The update to the predictor is still emitted alongside flush.
- Correct prediction: no flush; redirect_pc holds its last value.
- Push and non-mispredicting resolve in the same cycle: count unchanged, both pointers advance.
- Resolve with count = 0 (and not in a flush cycle):
  - No pop, no update, no flush.
  - err_underflow set to 1 and held until rst.
- count tracks accepted pushes minus pops, saturating naturally at 0..DEPTH by construction.

Decomposition:
- Shared package brq_pkg:
  - entry record (index IDX_W, pred 1, alt_pc PC_W) and its packed width constant.
  - default IDX_W/PC_W constants, shared with the predictor and fetch stages.
- One natural sub-module, brq_storage: DEPTH-entry register file with a write port at tail and a read port at head.
- Control (pointers, count, mispredict compare, output registers) stays in the top level.

Test Plan:
- Reset then idle: all outputs 0, push_ready = 1, count = 0 for 10 cycles.
- Push idx=0x12 pred=1 alt=0x100, then resolve taken=1 -> one cycle later upd_valid=1, upd_index=0x12, upd_taken=1, flush=0, count=0.
- Push 3 entries (pred 0,0,0; alt 0x200/0x204/0x208), resolve first with taken=1 -> next cycle flush=1, redirect_pc=0x200, upd_index=first idx, count=0, push_ready=0 that cycle only.
- Fill to DEPTH=4 -> push_ready=0. Assert push+resolve (correct) on the same cycle -> push not accepted, count=3. Then 8 further push/resolve pairs exercise pointer wrap; upd_index sequence must match push order exactly.
- Resolve with empty queue -> no upd_valid, no flush, err_underflow=1 held; stays 1 after later normal traffic until rst.
- Assert rst with 2 entries queued and a resolve pending -> after the edge count=0, upd_valid=0, flush=0. A subsequent resolve sets err_underflow.
